// File: rtl/disp_pkg.sv
// Shared encodings, glyph constants and digit indexing for the multimode clock display.
package disp_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_ALARM     = 2'd1,
    MODE_STOPWATCH = 2'd2,
    MODE_TIMER     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    FIELD_NONE    = 2'd0,
    FIELD_HOURS   = 2'd1,
    FIELD_MINUTES = 2'd2,
    FIELD_SECONDS = 2'd3
  } field_e;

  localparam int unsigned NUM_DIGITS = 9;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_P     = 7'h18;

  // Digit 0 sits in the top bits of the segment bus.
  function automatic int unsigned digit_lsb(input int unsigned d);
    return 56 - 7 * d;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment glyph {a,b,c,d,e,f,g}; non-decimal codes show a dash.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_mode_ctrl.sv
// Display scheduler: mode/edit FSMs, blink timing and a frame-synchronous segment register
// so the renderer never sees a partly updated image.
module disp_mode_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        FRAME_TICK,
  input  logic        MODE_BTN,
  input  logic        EDIT_BTN,
  input  logic        ALARM_RING,
  input  logic [35:0] CLK_BCD,
  input  logic        CLK_PM,
  input  logic [35:0] ALM_BCD,
  input  logic        ALM_PM,
  input  logic [35:0] SW_BCD,
  input  logic [35:0] TMR_BCD,
  output logic [62:0] con,
  output logic [6:0]  AP,
  output logic [1:0]  MODE,
  output logic [1:0]  EDIT_FIELD
);

  mode_e       mode_q, mode_d;
  field_e      field_q, field_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hidden_q, hidden_d;
  logic [62:0] con_q, con_d;
  logic [6:0]  ap_q, ap_d;

  mode_e       src_mode;
  logic [35:0] src_bcd;
  logic [62:0] glyph_bus;
  logic        pm;

  always_comb begin
    mode_d   = mode_q;
    field_d  = field_q;
    cnt_d    = cnt_q;
    hidden_d = hidden_q;
    if (MODE_BTN) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      field_d = FIELD_NONE;
    end else if (EDIT_BTN && (mode_q != MODE_STOPWATCH)) begin
      field_d = field_e'(field_q + 2'd1);
    end
    // Restart blinking visible whenever the edited field moves.
    if (field_d != field_q) begin
      cnt_d    = 8'd0;
      hidden_d = 1'b0;
    end else if (FRAME_TICK) begin
      if (cnt_q == 8'(BLINK_FRAMES - 1)) begin
        cnt_d    = 8'd0;
        hidden_d = ~hidden_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // A ringing alarm always shows the time of day.
  assign src_mode = ALARM_RING ? MODE_CLOCK : mode_q;

  always_comb begin
    src_bcd = CLK_BCD;
    pm      = CLK_PM;
    unique case (src_mode)
      MODE_CLOCK:     src_bcd = CLK_BCD;
      MODE_ALARM:     begin src_bcd = ALM_BCD; pm = ALM_PM; end
      MODE_STOPWATCH: src_bcd = SW_BCD;
      MODE_TIMER:     src_bcd = TMR_BCD;
    endcase
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    bcd_to_seg7 u_seg (
      .bcd (src_bcd[35-4*d -: 4]),
      .seg (glyph_bus[digit_lsb(d) +: 7])
    );
  end

  always_comb begin
    con_d = glyph_bus;
    ap_d  = SEG_BLANK;
    if (BLANK_LZ && (src_mode inside {MODE_CLOCK, MODE_ALARM}) && (src_bcd[35:32] == 4'd0)) begin
      con_d[62:56] = SEG_BLANK;
    end
    if (hidden_q && !ALARM_RING) begin
      unique case (field_q)
        FIELD_NONE:    ;
        FIELD_HOURS:   con_d[62:49] = '1;
        FIELD_MINUTES: con_d[48:35] = '1;
        FIELD_SECONDS: con_d[34:21] = '1;
      endcase
    end
    if (src_mode inside {MODE_CLOCK, MODE_ALARM}) begin
      ap_d = pm ? SEG_P : SEG_A;
    end
    if (ALARM_RING && hidden_q) begin
      con_d = '1;
      ap_d  = SEG_BLANK;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      mode_q   <= MODE_CLOCK;
      field_q  <= FIELD_NONE;
      cnt_q    <= 8'd0;
      hidden_q <= 1'b0;
      con_q    <= '1;
      ap_q     <= SEG_BLANK;
    end else begin
      mode_q   <= mode_d;
      field_q  <= field_d;
      cnt_q    <= cnt_d;
      hidden_q <= hidden_d;
      if (FRAME_TICK) begin
        con_q <= con_d;
        ap_q  <= ap_d;
      end
    end
  end

  assign con        = con_q;
  assign AP         = ap_q;
  assign MODE       = mode_q;
  assign EDIT_FIELD = field_q;

endmodule
